// File: rtl/epoch_scheduler.sv
// Epoch/sample sequencer driving the load, feed-forward and back-prop engines.
// Optional per-phase watchdog is compiled in when SCHED_WATCHDOG_EN is defined.
module epoch_scheduler #(
    parameter int CNT_W     = 16,
    parameter int WDT_LIMIT = 65535
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [CNT_W-1:0] num_samples,
    input  logic [CNT_W-1:0] num_epochs,
    input  logic             abort,
    input  logic             fin_ld,
    input  logic             fin_ff,
    input  logic             fin_bp,
    output logic             run_ld,
    output logic             run_ff,
    output logic             run_bp,
    output logic [CNT_W-1:0] sample_idx,
    output logic [CNT_W-1:0] epoch_idx,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD,
        S_FF,
        S_BP,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] ns_q, ns_d;
    logic [CNT_W-1:0] ne_q, ne_d;
    logic [CNT_W-1:0] sidx_q, sidx_d;
    logic [CNT_W-1:0] eidx_q, eidx_d;
    logic             run_ld_q, run_ld_d;
    logic             run_ff_q, run_ff_d;
    logic             run_bp_q, run_bp_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             wdt_expired;

`ifdef SCHED_WATCHDOG_EN
    localparam int               WDT_W    = (WDT_LIMIT > 1) ? $clog2(WDT_LIMIT) : 1;
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_LIMIT - 1);
    localparam logic [WDT_W-1:0] WDT_ONE  = WDT_W'(1);

    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic             err_q, err_d;

    assign wdt_expired = (wdt_q == WDT_LAST);

    // Counter restarts whenever a phase is (re)entered and only runs while parked in one.
    always_comb begin
        wdt_d = '0;
        if ((state_d == state_q) && (state_q inside {S_LD, S_FF, S_BP})) begin
            wdt_d = wdt_q + WDT_ONE;
        end
        err_d = err_q;
        if ((state_q == S_IDLE) && start) begin
            err_d = 1'b0;
        end
        if (state_d == S_ERR) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wdt_q <= '0;
            err_q <= 1'b0;
        end else begin
            wdt_q <= wdt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign wdt_expired = 1'b0;
    assign err         = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        ns_d    = ns_q;
        ne_d    = ne_q;
        sidx_d  = sidx_q;
        eidx_d  = eidx_q;

        // Abort wins over any phase completion seen in the same cycle.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sidx_d = '0;
                        eidx_d = '0;
                        if ((num_samples != '0) && (num_epochs != '0)) begin
                            mode_d  = mode;
                            ns_d    = num_samples;
                            ne_d    = num_epochs;
                            state_d = S_LD;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_LD: begin
                    if (fin_ld) begin
                        state_d = S_FF;
                    end else if (wdt_expired) begin
                        state_d = S_ERR;
                    end
                end
                S_FF: begin
                    if (fin_ff) begin
                        state_d = mode_q ? S_BP : S_NEXT;
                    end else if (wdt_expired) begin
                        state_d = S_ERR;
                    end
                end
                S_BP: begin
                    if (fin_bp) begin
                        state_d = S_NEXT;
                    end else if (wdt_expired) begin
                        state_d = S_ERR;
                    end
                end
                S_NEXT: begin
                    if (sidx_q < ns_q - CNT_ONE) begin
                        sidx_d  = sidx_q + CNT_ONE;
                        state_d = S_LD;
                    end else begin
                        sidx_d = '0;
                        if (eidx_q < ne_q - CNT_ONE) begin
                            eidx_d  = eidx_q + CNT_ONE;
                            state_d = S_LD;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Outputs are registered copies decoded from the next state.
        run_ld_d = (state_d == S_LD);
        run_ff_d = (state_d == S_FF);
        run_bp_d = (state_d == S_BP);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            ns_q     <= '0;
            ne_q     <= '0;
            sidx_q   <= '0;
            eidx_q   <= '0;
            run_ld_q <= 1'b0;
            run_ff_q <= 1'b0;
            run_bp_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            ns_q     <= ns_d;
            ne_q     <= ne_d;
            sidx_q   <= sidx_d;
            eidx_q   <= eidx_d;
            run_ld_q <= run_ld_d;
            run_ff_q <= run_ff_d;
            run_bp_q <= run_bp_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign run_ld     = run_ld_q;
    assign run_ff     = run_ff_q;
    assign run_bp     = run_bp_q;
    assign sample_idx = sidx_q;
    assign epoch_idx  = eidx_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
